elevator_ctrl: RTL and testbench

//  Downstream consumer of a mechanism's `active` flag (button/lever).

---
 rtl/elevator_ctrl.sv | 178 +++++++++++++++++
 tb/tb_elevator_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Vertical platform controller: moves one platform between Y_TOP and Y_BOTTOM
// at a frame-paced speed, driven by a mechanism's active flag.
module elevator_ctrl #(
  parameter logic [9:0] X_POS    = 10'd0,
  parameter logic [9:0] Y_TOP    = 10'd100,
  parameter logic [9:0] Y_BOTTOM = 10'd200,
  parameter logic [9:0] WIDTH    = 10'd64,
  parameter logic [9:0] HEIGHT   = 10'd8,
  parameter logic [3:0] STEP     = 4'd4,
  parameter logic [3:0] MOVE_DIV = 4'd2,
  parameter logic       LATCH    = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        active,
  output logic [39:0] plat_props,
  output logic [9:0]  dy,
  output logic        move_pulse,
  output logic        moving,
  output logic        at_top,
  output logic        at_bottom
);

  typedef enum logic [1:0] {
    ST_BOTTOM  = 2'd0,
    ST_RISING  = 2'd1,
    ST_TOP     = 2'd2,
    ST_FALLING = 2'd3
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [9:0]  y_r;
  logic [9:0]  y_next_s;
  logic [3:0]  div_r;
  logic [3:0]  div_next_s;
  logic        target_r;
  logic        active_d_r;
  logic        rise_edge_s;
  logic        target_up_s;
  logic        step_s;
  logic        div_last_s;
  logic [10:0] y_up_wide_s;
  logic [10:0] y_dn_wide_s;
  logic [9:0]  y_up_s;
  logic [9:0]  y_dn_s;

  assign plat_props = {X_POS, y_r, WIDTH, HEIGHT};

  // Target direction and clamped candidate positions for the next step.
  always_comb begin
    rise_edge_s = active & ~active_d_r;
    // In toggle mode the pending flip is seen in the same cycle as the edge.
    if (LATCH) begin
      target_up_s = target_r ^ rise_edge_s;
    end else begin
      target_up_s = active;
    end
    y_up_wide_s = {1'b0, y_r} - {7'd0, STEP};
    y_dn_wide_s = {1'b0, y_r} + {7'd0, STEP};
    if (y_up_wide_s[10] || (y_up_wide_s < {1'b0, Y_TOP})) begin
      y_up_s = Y_TOP;
    end else begin
      y_up_s = y_up_wide_s[9:0];
    end
    if (y_dn_wide_s > {1'b0, Y_BOTTOM}) begin
      y_dn_s = Y_BOTTOM;
    end else begin
      y_dn_s = y_dn_wide_s[9:0];
    end
    div_last_s = (div_r == (MOVE_DIV - 4'd1));
  end

  // Next-state, divider and step decision.
  always_comb begin
    next_state_s = state_r;
    div_next_s   = div_r;
    step_s       = 1'b0;
    y_next_s     = y_r;
    case (state_r)
      ST_BOTTOM: begin
        div_next_s = 4'd0;
        if (target_up_s) begin
          next_state_s = ST_RISING;
        end else begin
          next_state_s = ST_BOTTOM;
        end
      end
      ST_TOP: begin
        div_next_s = 4'd0;
        if (!target_up_s) begin
          next_state_s = ST_FALLING;
        end else begin
          next_state_s = ST_TOP;
        end
      end
      ST_RISING: begin
        if (!target_up_s) begin
          next_state_s = ST_FALLING;
          div_next_s   = 4'd0;
        end else if (frame_tick) begin
          if (div_last_s) begin
            div_next_s = 4'd0;
            step_s     = 1'b1;
            y_next_s   = y_up_s;
            if (y_up_s == Y_TOP) begin
              next_state_s = ST_TOP;
            end else begin
              next_state_s = ST_RISING;
            end
          end else begin
            div_next_s = div_r + 4'd1;
          end
        end else begin
          div_next_s = div_r;
        end
      end
      ST_FALLING: begin
        if (target_up_s) begin
          next_state_s = ST_RISING;
          div_next_s   = 4'd0;
        end else if (frame_tick) begin
          if (div_last_s) begin
            div_next_s = 4'd0;
            step_s     = 1'b1;
            y_next_s   = y_dn_s;
            if (y_dn_s == Y_BOTTOM) begin
              next_state_s = ST_BOTTOM;
            end else begin
              next_state_s = ST_FALLING;
            end
          end else begin
            div_next_s = div_r + 4'd1;
          end
        end else begin
          div_next_s = div_r;
        end
      end
      default: begin
        next_state_s = ST_BOTTOM;
        div_next_s   = 4'd0;
      end
    endcase
  end

  // State, position and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_BOTTOM;
      y_r        <= Y_BOTTOM;
      div_r      <= 4'd0;
      target_r   <= 1'b0;
      active_d_r <= 1'b0;
      dy         <= 10'd0;
      move_pulse <= 1'b0;
      moving     <= 1'b0;
      at_top     <= 1'b0;
      at_bottom  <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      y_r        <= y_next_s;
      div_r      <= div_next_s;
      target_r   <= target_up_s;
      active_d_r <= active;
      move_pulse <= step_s;
      if (step_s) begin
        dy <= y_next_s - y_r;
      end else begin
        dy <= 10'd0;
      end
      moving    <= (next_state_s == ST_RISING) || (next_state_s == ST_FALLING);
      at_top    <= (next_state_s == ST_TOP);
      at_bottom <= (next_state_s == ST_BOTTOM);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl: default, fast-clamp and toggle instances.
module tb_elevator_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic act_d = 1'b0;
  logic act_c = 1'b0;
  logic act_t = 1'b0;

  logic [39:0] props_d, props_c, props_t;
  logic [9:0]  dy_d, dy_c, dy_t;
  logic        mp_d, mp_c, mp_t;
  logic        mv_d, mv_c, mv_t;
  logic        top_d, top_c, top_t;
  logic        bot_d, bot_c, bot_t;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  elevator_ctrl u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .active(act_d),
    .plat_props(props_d), .dy(dy_d), .move_pulse(mp_d), .moving(mv_d),
    .at_top(top_d), .at_bottom(bot_d)
  );

  elevator_ctrl #(.STEP(4'd3), .MOVE_DIV(4'd1)) u_clamp (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .active(act_c),
    .plat_props(props_c), .dy(dy_c), .move_pulse(mp_c), .moving(mv_c),
    .at_top(top_c), .at_bottom(bot_c)
  );

  elevator_ctrl #(.LATCH(1'b1)) u_tog (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .active(act_t),
    .plat_props(props_t), .dy(dy_t), .move_pulse(mp_t), .moving(mv_t),
    .at_top(top_t), .at_bottom(bot_t)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: frame_tick driven on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic cyc(input logic ft);
    @(negedge clk);
    frame_tick = ft;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: reset state
    cyc(1'b0);
    chk("rst_props", props_d, {10'd0, 10'd200, 10'd64, 10'd8});
    chk("rst_bot", {39'd0, bot_d}, 40'd1);
    chk("rst_mv", {39'd0, mv_d}, 40'd0);
    chk("rst_top", {39'd0, top_d}, 40'd0);
    chk("rst_dy", {30'd0, dy_d}, 40'd0);
    chk("rst_mp", {39'd0, mp_d}, 40'd0);
    @(negedge clk);
    rst = 1'b0;

    // T2: level-mode rise and return
    act_d = 1'b1;
    cyc(1'b0);
    chk("t2_moving", {39'd0, mv_d}, 40'd1);
    chk("t2_y_hold", {30'd0, props_d[29:20]}, 40'd200);
    cyc(1'b1);
    chk("t2_first_tick_nopulse", {39'd0, mp_d}, 40'd0);
    cyc(1'b1);
    chk("t2_y196", {30'd0, props_d[29:20]}, 40'd196);
    chk("t2_dy", {30'd0, dy_d}, 40'h3FC);
    chk("t2_pulse", {39'd0, mp_d}, 40'd1);
    cyc(1'b0);
    chk("t2_pulse_clr", {39'd0, mp_d}, 40'd0);
    chk("t2_dy_clr", {30'd0, dy_d}, 40'd0);
    for (int k = 2; k <= 25; k++) begin
      cyc(1'b1);
      cyc(1'b1);
      chk("t2_rise_y", {30'd0, props_d[29:20]}, 40'(200 - 4 * k));
    end
    chk("t2_at_top", {39'd0, top_d}, 40'd1);
    chk("t2_top_nomv", {39'd0, mv_d}, 40'd0);
    cyc(1'b1);
    cyc(1'b1);
    chk("t2_top_hold", {30'd0, props_d[29:20]}, 40'd100);
    act_d = 1'b0;
    cyc(1'b0);
    chk("t2_fall_mv", {39'd0, mv_d}, 40'd1);
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b1);
      cyc(1'b1);
      chk("t2_fall_y", {30'd0, props_d[29:20]}, 40'(100 + 4 * k));
    end
    chk("t2_fall_dy", {30'd0, dy_d}, 40'd4);
    chk("t2_at_bot", {39'd0, bot_d}, 40'd1);

    // T1 again: reset mid-move
    act_d = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    chk("t1_pre_y", {30'd0, props_d[29:20]}, 40'd196);
    rst = 1'b1;
    #1;
    chk("t1_mid_y", {30'd0, props_d[29:20]}, 40'd200);
    chk("t1_mid_bot", {39'd0, bot_d}, 40'd1);
    chk("t1_mid_mv", {39'd0, mv_d}, 40'd0);
    chk("t1_mid_dy", {30'd0, dy_d}, 40'd0);
    chk("t1_mid_mp", {39'd0, mp_d}, 40'd0);
    act_d = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // T3: clamp with STEP=3, MOVE_DIV=1
    act_c = 1'b1;
    cyc(1'b0);
    for (int k = 1; k <= 33; k++) begin
      cyc(1'b1);
      chk("t3_y", {30'd0, props_c[29:20]}, 40'(200 - 3 * k));
    end
    chk("t3_101_not_top", {39'd0, top_c}, 40'd0);
    cyc(1'b1);
    chk("t3_y100", {30'd0, props_c[29:20]}, 40'd100);
    chk("t3_dy_m1", {30'd0, dy_c}, 40'h3FF);
    chk("t3_at_top", {39'd0, top_c}, 40'd1);
    act_c = 1'b0;
    cyc(1'b0);
    for (int k = 1; k <= 34; k++) cyc(1'b1);
    chk("t3_back_bot", {39'd0, bot_c}, 40'd1);
    chk("t3_back_y", {30'd0, props_c[29:20]}, 40'd200);

    // T4: reversal at y=160 with a coincident tick after div has advanced
    act_d = 1'b1;
    cyc(1'b0);
    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1);
      cyc(1'b1);
    end
    chk("t4_y160", {30'd0, props_d[29:20]}, 40'd160);
    cyc(1'b1);
    act_d = 1'b0;
    cyc(1'b1);
    chk("t4_rev_y", {30'd0, props_d[29:20]}, 40'd160);
    chk("t4_rev_mp", {39'd0, mp_d}, 40'd0);
    chk("t4_rev_mv", {39'd0, mv_d}, 40'd1);
    cyc(1'b1);
    chk("t4_div_reset", {39'd0, mp_d}, 40'd0);
    cyc(1'b1);
    chk("t4_y164", {30'd0, props_d[29:20]}, 40'd164);
    chk("t4_dy4", {30'd0, dy_d}, 40'd4);
    for (int k = 2; k <= 10; k++) begin
      cyc(1'b1);
      cyc(1'b1);
      chk("t4_fall_y", {30'd0, props_d[29:20]}, 40'(160 + 4 * k));
    end
    chk("t4_at_bot", {39'd0, bot_d}, 40'd1);

    // T6: active edge coincident with frame_tick from BOTTOM
    act_d = 1'b1;
    cyc(1'b1);
    chk("t6_mv", {39'd0, mv_d}, 40'd1);
    chk("t6_y", {30'd0, props_d[29:20]}, 40'd200);
    chk("t6_mp", {39'd0, mp_d}, 40'd0);
    cyc(1'b1);
    chk("t6_div_mp", {39'd0, mp_d}, 40'd0);
    cyc(1'b1);
    chk("t6_y196", {30'd0, props_d[29:20]}, 40'd196);
    act_d = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    chk("t6_back_bot", {39'd0, bot_d}, 40'd1);

    // T5: toggle mode
    act_t = 1'b1;
    cyc(1'b0);
    act_t = 1'b0;
    chk("t5_mv", {39'd0, mv_t}, 40'd1);
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b1);
      cyc(1'b1);
    end
    chk("t5_top_y", {30'd0, props_t[29:20]}, 40'd100);
    chk("t5_at_top", {39'd0, top_t}, 40'd1);
    for (int k = 0; k < 6; k++) cyc(1'b1);
    chk("t5_stays_top", {39'd0, top_t}, 40'd1);
    act_t = 1'b1;
    for (int k = 0; k < 10; k++) cyc(1'b0);
    act_t = 1'b0;
    cyc(1'b0);
    chk("t5_hold_one_toggle", {39'd0, mv_t}, 40'd1);
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b1);
      cyc(1'b1);
    end
    chk("t5_bot_y", {30'd0, props_t[29:20]}, 40'd200);
    chk("t5_at_bot", {39'd0, bot_t}, 40'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
